inst_fetch: RTL and testbench

//   Instruction fetch stage that sits directly upstream of the instruction memory.
//   It owns the fetch PC and drives the word read address every cycle.
//   It tracks the memory's fixed 2-cycle read latency and buffers returned words in a FIFO.
//   It presents {pc, inst} to decode over a valid/ready handshake and supports a redirect
//   (branch/jump) that flushes all stale fetches.

---
 rtl/inst_fetch.sv | 118 +++++++++++
 tb/tb_inst_fetch.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the fetch PC, tracks the fixed-latency imem read pipe,
// and buffers returned words in a FIFO presented to decode over valid/ready.
module inst_fetch #(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter int          FIFO_DEPTH = 4,
    parameter int          MEM_LAT    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [14:0] imem_raddr_,
    input  logic [15:0] imem_rdata_,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    output logic        inst_valid,
    output logic [15:0] inst_data,
    output logic [15:0] inst_pc,
    input  logic        inst_ready
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + MEM_LAT + 1);

    logic [15:0]      fetch_pc;
    logic [MEM_LAT-1:0] pipe_valid;
    logic [15:0]      pipe_pc [MEM_LAT];

    logic [15:0]      fifo_data [FIFO_DEPTH];
    logic [15:0]      fifo_pc   [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] fifo_count;

    logic [CNT_W-1:0] inflight_count;
    logic             issue;
    logic             push;
    logic             pop;

    // Credit counts every wanted fetch, including the one landing this edge, so the
    // FIFO always has a free slot for whatever the pipe delivers.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
        inflight_count = '0;
        for (int i = 0; i < MEM_LAT; i++) begin
            inflight_count = inflight_count + CNT_W'(pipe_valid[i]);
        end
    end

    assign issue = !redirect_valid && ((fifo_count + inflight_count) < CNT_W'(FIFO_DEPTH));
    assign push  = pipe_valid[MEM_LAT-1] && !redirect_valid;
    assign pop   = inst_valid && inst_ready && !redirect_valid;

    assign imem_raddr_ = fetch_pc[15:1];

    // NOTE: sequential state is written with <= so every register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc <= RESET_PC & 16'hFFFE;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_pc & 16'hFFFE;
        end else if (issue) begin
            fetch_pc <= fetch_pc + 16'd2;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_valid <= '0;
        end else if (redirect_valid) begin
            pipe_valid <= '0;
        end else begin
            pipe_valid[0] <= issue;
            for (int i = 1; i < MEM_LAT; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
            end
        end
    end

    // PCs travel alongside the valid bits; only the valid bits need a defined reset value.
    always_ff @(posedge clk) begin
        pipe_pc[0] <= fetch_pc;
        for (int i = 1; i < MEM_LAT; i++) begin
            pipe_pc[i] <= pipe_pc[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else if (redirect_valid) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // NOTE: FIFO storage is not reset; occupancy is tracked by the counters and the outputs are gated when empty.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= imem_rdata_;
            fifo_pc[wr_ptr]   <= pipe_pc[MEM_LAT-1];
        end
    end

    assign inst_valid = (fifo_count != '0);
    assign inst_data  = inst_valid ? fifo_data[rd_ptr] : 16'h0000;
    assign inst_pc    = inst_valid ? fifo_pc[rd_ptr]   : 16'h0000;

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: a 2-cycle imem model plus a queue of expected
// {pc, inst} pairs reloaded on every reset release and redirect.
module tb_inst_fetch;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [14:0] imem_raddr_;
    logic [15:0] imem_rdata_;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        inst_valid;
    logic [15:0] inst_data;
    logic [15:0] inst_pc;
    logic        inst_ready;

    logic [14:0] mem_r1;
    logic [14:0] mem_r2;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   pop_count = 0;

    inst_fetch #(
        .RESET_PC   (16'h0000),
        .FIFO_DEPTH (4),
        .MEM_LAT    (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_raddr_    (imem_raddr_),
        .imem_rdata_    (imem_rdata_),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] memfn(input logic [14:0] w);
        return 16'hA000 + {1'b0, w};
    endfunction

    // Instruction memory: address sampled at two edges, data valid two cycles later.
    always @(posedge clk) begin
        mem_r1 <= imem_raddr_;
        mem_r2 <= mem_r1;
    end
    assign imem_rdata_ = memfn(mem_r2);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic sb_load(input logic [15:0] start);
        logic [15:0] p;
        exp_t e;
        p = start & 16'hFFFE;
        sb_q.delete();
        for (int i = 0; i < 64; i++) begin
            e.pc   = p;
            e.data = memfn(p[15:1]);
            sb_q.push_back(e);
            p = p + 16'd2;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Every accepted handshake must match the head of the expected stream.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && !redirect_valid && inst_valid && inst_ready) begin
            pop_count++;
            if (sb_q.size() == 0) begin
                check("sb_unexpected_pop", 32'(inst_pc), 32'hFFFF_FFFF);
            end else begin
                e = sb_q.pop_front();
                check("sb_pc", 32'(inst_pc), 32'(e.pc));
                check("sb_data", 32'(inst_data), 32'(e.data));
            end
        end
    end

    task automatic do_redirect(input logic [15:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        sb_load(pc);
        step();
        redirect_valid = 1'b0;
    endtask

    // Checks cycles R+1..R+4 after a redirect issued by do_redirect (called in cycle R).
    task automatic check_restart(input string tag, input logic [15:0] pc);
        logic [15:0] p;
        p = pc & 16'hFFFE;
        @(negedge clk);
        check({tag, "_r1_valid"}, 32'(inst_valid), 32'd0);
        check({tag, "_r1_raddr"}, 32'(imem_raddr_), 32'(p[15:1]));
        step();
        for (int c = 2; c < 4; c++) begin
            @(negedge clk);
            check({tag, "_bubble"}, 32'(inst_valid), 32'd0);
            step();
        end
        @(negedge clk);
        check({tag, "_r4_valid"}, 32'(inst_valid), 32'd1);
        check({tag, "_r4_pc"}, 32'(inst_pc), 32'(p));
        check({tag, "_r4_data"}, 32'(inst_data), 32'(memfn(p[15:1])));
        step();
    endtask

    initial begin
        int pops_before;
        rst            = 1'b1;
        inst_ready     = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 16'h0000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 32'(inst_valid), 32'd0);
        check("rst_data", 32'(inst_data), 32'd0);
        check("rst_pc", 32'(inst_pc), 32'd0);
        check("rst_raddr", 32'(imem_raddr_), 32'd0);
        step();

        // Reset release: first instruction in cycle 3, then one per cycle.
        rst = 1'b0;
        sb_load(16'h0000);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("t1_bubble", 32'(inst_valid), 32'd0);
            step();
        end
        @(negedge clk);
        check("t1_first_pc", 32'(inst_pc), 32'h0000);
        check("t1_first_data", 32'(inst_data), 32'hA000);
        step();
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("t1_stream_valid", 32'(inst_valid), 32'd1);
            step();
        end

        // Stall: credit stops issue with exactly FIFO_DEPTH entries buffered.
        inst_ready = 1'b0;
        repeat (10) step();
        @(negedge clk);
        check("t2_head_valid", 32'(inst_valid), 32'd1);
        check("t2_head_pc", 32'(inst_pc), 32'(sb_q[0].pc));
        check("t2_raddr_hold", 32'(imem_raddr_), 32'((sb_q[0].pc + 16'd8) >> 1));
        step();
        inst_ready = 1'b1;
        repeat (8) step();

        // Redirect while backed up; odd PC is forced even.
        inst_ready = 1'b0;
        repeat (2) step();
        inst_ready = 1'b1;
        do_redirect(16'h0101);
        check_restart("t3", 16'h0101);
        repeat (4) step();

        // Redirect in the same cycle as a handshake: the popped entry must not reappear.
        @(negedge clk);
        check("t4_pre_valid", 32'(inst_valid), 32'd1);
        step();
        do_redirect(16'h0200);
        check_restart("t4", 16'h0200);
        repeat (3) step();

        // Back-to-back redirects: the second wins.
        do_redirect(16'h0300);
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0400;
        sb_load(16'h0400);
        step();
        redirect_valid = 1'b0;
        check_restart("t4b", 16'h0400);
        repeat (3) step();

        // PC wrap across 16'hFFFE.
        do_redirect(16'hFFFC);
        pops_before = pop_count;
        check_restart("t5", 16'hFFFC);
        repeat (3) step();
        check("t5_pop_count", 32'(pop_count - pops_before), 32'd4);

        // Mid-operation reset with entries buffered and fetches in flight.
        inst_ready = 1'b0;
        repeat (2) step();
        rst = 1'b1;
        #1;
        check("t6_rst_valid", 32'(inst_valid), 32'd0);
        check("t6_rst_data", 32'(inst_data), 32'd0);
        check("t6_rst_pc", 32'(inst_pc), 32'd0);
        check("t6_rst_raddr", 32'(imem_raddr_), 32'd0);
        step();
        inst_ready = 1'b1;
        rst = 1'b0;
        sb_load(16'h0000);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("t6_bubble", 32'(inst_valid), 32'd0);
            step();
        end
        @(negedge clk);
        check("t6_first_pc", 32'(inst_pc), 32'h0000);
        check("t6_first_data", 32'(inst_data), 32'hA000);
        step();
        repeat (4) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
